game_flow_ctrl: RTL and testbench

- Top-level sequencer for the Breakout game. It owns the screen state (start, game, pause, end), the lives and level counters, and the serve delay.
- It generates the reset and run-enable that gate the game core, and its state output drives the picture mux.
- Inputs are debounced single-cycle key flags, a frame-start pulse, and event pulses from the game core.

---
 rtl/game_flow_if.sv | 26 ++
 rtl/game_flow_ctrl.sv | 138 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_if.sv
// Handshake bundle between the Breakout flow sequencer and the key/video/game-core side.
// The master modport belongs to the sequencer; the slave modport to whoever drives its flags.
interface game_flow_if;
  logic       ok_flag;
  logic       back_flag;
  logic       frame_start;
  logic       ball_lost;
  logic       level_clear;
  logic [1:0] state;
  logic       game_rst_n;
  logic       ball_rst;
  logic       run_en;
  logic [2:0] lives;
  logic [3:0] level;
  logic       win;

  modport master (
    input  ok_flag, back_flag, frame_start, ball_lost, level_clear,
    output state, game_rst_n, ball_rst, run_en, lives, level, win
  );

  modport slave (
    output ok_flag, back_flag, frame_start, ball_lost, level_clear,
    input  state, game_rst_n, ball_rst, run_en, lives, level, win
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Breakout screen sequencer: owns START/GAME/PAUSE/END, lives, level, serve delay
// and the game-core reset pulse. All outputs are registered.
module game_flow_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int LEVEL_MAX    = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int RST_CYCLES   = 4
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  game_flow_if.master bus
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_GAME  = 2'd1,
    ST_END   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  state_t     state_r;
  logic [2:0] lives_r;
  logic [3:0] level_r;
  logic       win_r;
  logic       run_en_r;
  logic       ball_rst_r;
  logic       game_rst_n_r;
  logic [7:0] serve_cnt_r;
  logic [3:0] rst_cnt_r;

  // Core events are meaningless while the core itself is being reset.
  logic lc_s;
  logic bl_s;
  assign lc_s = bus.level_clear & (rst_cnt_r == 4'd0);
  assign bl_s = bus.ball_lost   & (rst_cnt_r == 4'd0);

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_r      <= ST_START;
      lives_r      <= 3'd0;
      level_r      <= 4'd0;
      win_r        <= 1'b0;
      run_en_r     <= 1'b0;
      ball_rst_r   <= 1'b0;
      game_rst_n_r <= 1'b0;
      serve_cnt_r  <= 8'd0;
      rst_cnt_r    <= 4'd0;
    end else begin
      ball_rst_r <= 1'b0;
      run_en_r   <= (state_r == ST_GAME) && (serve_cnt_r == 8'd0) && (rst_cnt_r == 4'd0);

      // game_rst_n rises on the edge where the counter expires.
      if (rst_cnt_r != 4'd0) begin
        rst_cnt_r    <= rst_cnt_r - 4'd1;
        game_rst_n_r <= (rst_cnt_r == 4'd1);
      end else begin
        game_rst_n_r <= 1'b1;
      end

      // Serve countdown; a serve load below overrides this decrement.
      if (bus.frame_start && (state_r == ST_GAME) && (serve_cnt_r != 8'd0)) begin
        serve_cnt_r <= serve_cnt_r - 8'd1;
      end else begin
        serve_cnt_r <= serve_cnt_r;
      end

      case (state_r)
        ST_START: begin
          if (bus.ok_flag) begin
            state_r      <= ST_GAME;
            lives_r      <= 3'(LIVES_INIT);
            level_r      <= 4'd1;
            win_r        <= 1'b0;
            rst_cnt_r    <= 4'(RST_CYCLES);
            game_rst_n_r <= 1'b0;
            serve_cnt_r  <= 8'(SERVE_FRAMES);
          end else begin
            state_r <= ST_START;
          end
        end
        ST_GAME: begin
          if (lc_s && (level_r == 4'(LEVEL_MAX))) begin
            state_r <= ST_END;
            win_r   <= 1'b1;
          end else if (lc_s) begin
            level_r      <= level_r + 4'd1;
            rst_cnt_r    <= 4'(RST_CYCLES);
            game_rst_n_r <= 1'b0;
            serve_cnt_r  <= 8'(SERVE_FRAMES);
          end else if (bl_s && (lives_r <= 3'd1)) begin
            state_r <= ST_END;
            lives_r <= 3'd0;
            win_r   <= 1'b0;
          end else if (bl_s) begin
            lives_r     <= lives_r - 3'd1;
            ball_rst_r  <= 1'b1;
            serve_cnt_r <= 8'(SERVE_FRAMES);
          end else if (bus.back_flag) begin
            state_r <= ST_PAUSE;
          end else begin
            state_r <= ST_GAME;
          end
        end
        ST_PAUSE: begin
          if (bus.back_flag) begin
            state_r <= ST_START;
            lives_r <= 3'd0;
            level_r <= 4'd0;
          end else if (bus.ok_flag) begin
            state_r <= ST_GAME;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_END: begin
          if (bus.ok_flag || bus.back_flag) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_END;
          end
        end
        default: begin
          state_r <= ST_START;
        end
      endcase
    end
  end

  assign bus.state      = state_r;
  assign bus.lives      = lives_r;
  assign bus.level      = level_r;
  assign bus.win        = win_r;
  assign bus.run_en     = run_en_r;
  assign bus.ball_rst   = ball_rst_r;
  assign bus.game_rst_n = game_rst_n_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with default parameters
// (3 lives, 4 levels, 60 serve frames, 4-cycle core reset).
module tb_game_flow_ctrl;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  game_flow_if bus();

  game_flow_ctrl dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse(input logic ok, input logic back, input logic bl,
                       input logic lc, input logic fs);
    bus.ok_flag     = ok;
    bus.back_flag   = back;
    bus.ball_lost   = bl;
    bus.level_clear = lc;
    bus.frame_start = fs;
    tick();
    bus.ok_flag     = 1'b0;
    bus.back_flag   = 1'b0;
    bus.ball_lost   = 1'b0;
    bus.level_clear = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
  endtask

  // Checks a freshly triggered core reset stays low exactly 4 cycles.
  task automatic check_rst_pulse(input string tag);
    check_val({tag, "_grst_lo0"}, int'(bus.game_rst_n), 0);
    repeat (3) tick();
    check_val({tag, "_grst_lo3"}, int'(bus.game_rst_n), 0);
    tick();
    check_val({tag, "_grst_hi"}, int'(bus.game_rst_n), 1);
  endtask

  initial begin
    bus.ok_flag     = 1'b0;
    bus.back_flag   = 1'b0;
    bus.frame_start = 1'b0;
    bus.ball_lost   = 1'b0;
    bus.level_clear = 1'b0;

    // Reset state
    tick(); tick();
    check_val("rst_state",  int'(bus.state), 0);
    check_val("rst_lives",  int'(bus.lives), 0);
    check_val("rst_level",  int'(bus.level), 0);
    check_val("rst_win",    int'(bus.win), 0);
    check_val("rst_run",    int'(bus.run_en), 0);
    check_val("rst_ballr",  int'(bus.ball_rst), 0);
    check_val("rst_grst",   int'(bus.game_rst_n), 0);
    sys_rst_n = 1'b1;
    tick();
    check_val("rel_grst", int'(bus.game_rst_n), 1);

    // Start a game
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("start_state", int'(bus.state), 1);
    check_val("start_lives", int'(bus.lives), 3);
    check_val("start_level", int'(bus.level), 1);
    check_rst_pulse("start");
    frames(59);
    check_val("serve59_run", int'(bus.run_en), 0);
    frames(1);
    tick();
    check_val("serve60_run", int'(bus.run_en), 1);

    // Ball lost with a coincident frame_start: load must win over decrement
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("bl1_lives", int'(bus.lives), 2);
    check_val("bl1_ballr", int'(bus.ball_rst), 1);
    tick();
    check_val("bl1_ballr_off", int'(bus.ball_rst), 0);
    check_val("bl1_run_off", int'(bus.run_en), 0);
    frames(59);
    check_val("bl1_serve59_run", int'(bus.run_en), 0);
    frames(1);
    tick();
    check_val("bl1_serve60_run", int'(bus.run_en), 1);

    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("bl2_lives", int'(bus.lives), 1);
    tick();
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("bl3_state", int'(bus.state), 2);
    check_val("bl3_lives", int'(bus.lives), 0);
    check_val("bl3_win",   int'(bus.win), 0);

    // END -> START keeps lives/level
    tick();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("end_ok_state", int'(bus.state), 0);
    check_val("end_ok_lives", int'(bus.lives), 0);
    check_val("end_ok_level", int'(bus.level), 1);

    // Restart; a ball_lost during core reset is dropped
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("re_lives", int'(bus.lives), 3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("drop_lives", int'(bus.lives), 3);
    check_val("drop_ballr", int'(bus.ball_rst), 0);
    repeat (4) tick();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("re_bl_lives", int'(bus.lives), 2);
    tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("lc1_level", int'(bus.level), 2);
    check_rst_pulse("lc1");

    // level_clear and ball_lost together at level 2, lives 2
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("both_level", int'(bus.level), 3);
    check_val("both_lives", int'(bus.lives), 2);
    check_val("both_ballr", int'(bus.ball_rst), 0);
    check_rst_pulse("lc2");
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("lc3_level", int'(bus.level), 4);
    check_rst_pulse("lc3");
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("lc4_state", int'(bus.state), 2);
    check_val("lc4_win",   int'(bus.win), 1);
    check_val("lc4_level", int'(bus.level), 4);

    // END + back -> START, then fresh game clears win
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("end_back_state", int'(bus.state), 0);
    check_val("end_back_win",   int'(bus.win), 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("g3_win",   int'(bus.win), 0);
    check_val("g3_level", int'(bus.level), 1);
    repeat (4) tick();

    // Pause after 20 serve frames freezes the countdown
    frames(20);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pause_state", int'(bus.state), 3);
    frames(100);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("pause_hold_state", int'(bus.state), 3);
    check_val("pause_hold_lives", int'(bus.lives), 3);
    check_val("pause_hold_level", int'(bus.level), 1);
    check_val("pause_run", int'(bus.run_en), 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("resume_state", int'(bus.state), 1);
    frames(39);
    check_val("resume39_run", int'(bus.run_en), 0);
    frames(1);
    tick();
    check_val("resume40_run", int'(bus.run_en), 1);

    // PAUSE with ok and back together: back wins
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pause2_state", int'(bus.state), 3);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("quit_state", int'(bus.state), 0);
    check_val("quit_lives", int'(bus.lives), 0);
    check_val("quit_level", int'(bus.level), 0);

    // Mid-game system reset
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    sys_rst_n = 1'b0;
    tick();
    check_val("midrst_state", int'(bus.state), 0);
    check_val("midrst_lives", int'(bus.lives), 0);
    check_val("midrst_level", int'(bus.level), 0);
    check_val("midrst_grst",  int'(bus.game_rst_n), 0);
    check_val("midrst_run",   int'(bus.run_en), 0);
    sys_rst_n = 1'b1;
    tick();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("after_rst_lives", int'(bus.lives), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
